onchip_mem_copy_master: RTL and testbench
=========================================

Name: onchip_mem_copy_master

Overview:
- Avalon-MM master that drives the single-port on-chip RAM slave interface (address, byteenable, chipselect, write, writedata, clken, readdata).
- On command, copies a block of 32-bit words from a source word address to a destination word address in the same RAM.
- Sits between a control register block (or Nios II PIO) and the RAM's second slave port.
- Used for buffer moves, such as ECG sample-window relocation, without CPU load/store loops.

Parameters:
- ADDR_W, 15, RAM word-address width; matches the RAM address port.
- MEM_DEPTH, 20480, RAM depth in words; all addresses wrap modulo MEM_DEPTH.
- LEN_W, 15, width of the length and count fields.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- abort  in  1  stop after the current word completes.
- src_addr  in  ADDR_W  first source word address.
- dst_addr  in  ADDR_W  first destination word address.
- length  in  LEN_W  number of words to copy.
- busy  out  1  high from the cycle after an accepted start until DONE is entered.
- done  out  1  one-cycle pulse when the copy ends, whether by completion, abort or zero length.
- words_done  out  LEN_W  number of words written in the current or last job.
- address  out  ADDR_W  master address to the RAM.
- byteenable  out  4  always 4'hF.
- chipselect  out  1  RAM access strobe.
- write  out  1  write qualifier.
- writedata  out  32  data to the RAM.
- clken  out  1  RAM clock enable; 1 whenever not in reset.
- readdata  in  32  RAM read data; valid exactly 1 cycle after a read access, with no waitrequest.

Behaviour:
- Reset values:
  - Registered outputs: busy, done, chipselect and write are 0; words_done, address and writedata are 0.
  - byteenable is constant 4'hF.
  - clken is combinational ~reset, so it is 0 during reset.
- States: IDLE, RD, LAT, WR, DONE.
- IDLE:
  - On start with length==0, go to DONE; no RAM access occurs.
  - On start with length!=0, latch src_addr, dst_addr and length into internal registers, clear words_done, and go to RD.
  - start while not in IDLE is ignored.
- RD: drive chipselect=1, write=0, address=src_ptr; go to LAT.
- LAT:
  - chipselect=0.
  - Capture readdata into data_reg; this is exactly one cycle after RD, so readdata is valid.
  - Go to WR.
- WR:
  - Drive chipselect=1, write=1, address=dst_ptr, writedata=data_reg.
  - Increment words_done and advance both pointers with wrap.
  - If words_done+1==length or abort_pend, go to DONE; otherwise go to RD.
- DONE: done=1 for one cycle, busy=0; go to IDLE.
- Throughput: 3 cycles per word. Latency from start to done is 3*length+2 cycles, with done asserted in cycle 3*length+2 counting the start cycle as 0.
- Pointer wrap: next = (ptr==MEM_DEPTH-1) ? 0 : ptr+1. src_addr and dst_addr inputs at or above MEM_DEPTH are reduced by MEM_DEPTH once at latch.
- Address drive: the address output is driven only in RD and WR; in other states it holds its last value.
- abort:
  - Any cycle busy is high, abort sets abort_pend.
  - The in-flight word finishes its WR, then the FSM goes to DONE; this completes the word, so no partial write occurs.
  - abort in IDLE has no effect.
  - abort_pend clears in DONE.
- Overlap: overlapping src/dst ranges are copied strictly in ascending order, with each word read before its write. Forward overlap with dst>src therefore replicates data; this is defined behaviour, not an error.
- words_done: holds its value after DONE until the next accepted start.
- Reset mid-operation: the FSM returns to IDLE next edge, strobes drop, and no further write is issued. A write strobe already in the reset cycle is not suppressed.
- Simultaneous start and abort in IDLE: start is accepted and abort is ignored.

Test Plan:
- Basic copy:
  - Stimulus: preload RAM[100..103]=A0..A3, start with src=100, dst=200, len=4.
  - Response: RAM[200..203]=A0..A3, done in cycle 14, words_done=4, and exactly 4 write strobes.
- Zero length:
  - Stimulus: start with len=0.
  - Response: done in cycle 2, chipselect never asserted, words_done=0.
- Wrap:
  - Stimulus: start with src=20478, dst=10, len=4.
  - Response: reads addresses 20478, 20479, 0, 1 and writes addresses 10..13 in order.
- Abort:
  - Stimulus: start with len=10, assert abort in the cycle of the 3rd word's LAT.
  - Response: exactly 3 words written, words_done=3, done pulse follows that WR.
- Reset mid-copy:
  - Stimulus: assert reset during the 2nd word's RD.
  - Response: next cycle busy=0, chipselect=0, write=0, and the destination word at dst+1 is unchanged.
- Ignored start:
  - Stimulus: issue a start while busy with different addresses.
  - Response: the first job completes unaltered and no second job runs.

Source files
------------

// File: rtl/onchip_mem_copy_master_if.sv
// ----------------------------------------------------------------------------
// onchip_mem_copy_master_if
// Avalon-MM bundle between the copy master and the single-port on-chip RAM.
//   address    : word address to the RAM
//   byteenable : byte lanes (the master always drives all four)
//   chipselect : access strobe
//   write      : write qualifier (0 = read access)
//   writedata  : data to the RAM
//   clken      : RAM clock enable
//   readdata   : RAM read data, valid one cycle after a read access
// ----------------------------------------------------------------------------
interface onchip_mem_copy_master_if #(
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect;
    logic              write;
    logic [31:0]       writedata;
    logic              clken;
    logic [31:0]       readdata;

    modport master (
        output address, byteenable, chipselect, write, writedata, clken,
        input  readdata
    );

    modport slave (
        input  address, byteenable, chipselect, write, writedata, clken,
        output readdata
    );
endinterface

// File: rtl/onchip_mem_copy_master.sv
// ----------------------------------------------------------------------------
// onchip_mem_copy_master
// Copies a block of 32-bit words inside one on-chip RAM, one word every three
// cycles (RD -> LAT -> WR), in strictly ascending address order.
//   clk, reset          : clock, synchronous active-high reset
//   start, abort        : job start pulse (IDLE only), stop after current word
//   src_addr, dst_addr  : first source / destination word address
//   length              : number of words to copy
//   busy, done          : job in progress, one-cycle end-of-job pulse
//   words_done          : words written in the current or last job
//   bus                 : Avalon-MM master towards the RAM
// ----------------------------------------------------------------------------
module onchip_mem_copy_master #(
    parameter int ADDR_W    = 15,
    parameter int MEM_DEPTH = 20480,
    parameter int LEN_W     = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done,
    onchip_mem_copy_master_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_LAT  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] src_ptr_r;
    logic [ADDR_W-1:0] dst_ptr_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  words_done_r;
    logic              abort_pend_r;
    logic              busy_r;
    logic              done_r;
    logic              chipselect_r;
    logic              write_r;
    logic [ADDR_W-1:0] address_r;
    logic [31:0]       writedata_r;
    logic              start_ok_s;
    logic              last_word_s;
    logic [ADDR_W-1:0] src_in_s;
    logic [ADDR_W-1:0] dst_in_s;

    // Increment a word pointer, wrapping at the end of the RAM.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] p);
        return (p == ADDR_W'(MEM_DEPTH - 1)) ? {ADDR_W{1'b0}} : p + ADDR_W'(1);
    endfunction

    // Fold an out-of-range start address back into the RAM once.
    function automatic logic [ADDR_W-1:0] fold_addr(input logic [ADDR_W-1:0] a);
        return (a >= ADDR_W'(MEM_DEPTH)) ? a - ADDR_W'(MEM_DEPTH) : a;
    endfunction

    assign start_ok_s  = (state_r == S_IDLE) && start;
    assign last_word_s = ((words_done_r + LEN_W'(1)) == len_r);
    assign src_in_s    = fold_addr(src_addr);
    assign dst_in_s    = fold_addr(dst_addr);

    // Next-state logic of the copy sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if (length == {LEN_W{1'b0}}) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_RD;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RD:   state_s = S_LAT;
            S_LAT:  state_s = S_WR;
            S_WR: begin
                if (last_word_s || abort_pend_r) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_RD;
                end
            end
            S_DONE: state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Job pointers and word counter. The source pointer steps while leaving RD
    // so it is already current when the next RD address is registered at the
    // end of WR; the destination pointer steps while leaving WR.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_ptr_r    <= {ADDR_W{1'b0}};
            dst_ptr_r    <= {ADDR_W{1'b0}};
            len_r        <= {LEN_W{1'b0}};
            words_done_r <= {LEN_W{1'b0}};
        end else if (start_ok_s) begin
            src_ptr_r    <= src_in_s;
            dst_ptr_r    <= dst_in_s;
            len_r        <= length;
            words_done_r <= {LEN_W{1'b0}};
        end else if (state_r == S_RD) begin
            src_ptr_r    <= wrap_inc(src_ptr_r);
        end else if (state_r == S_WR) begin
            dst_ptr_r    <= wrap_inc(dst_ptr_r);
            words_done_r <= words_done_r + LEN_W'(1);
        end
    end

    // Abort request: remembered while busy, dropped when the job ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            abort_pend_r <= 1'b0;
        end else if (state_r == S_DONE) begin
            abort_pend_r <= 1'b0;
        end else if (busy_r && abort) begin
            abort_pend_r <= 1'b1;
        end
    end

    // Registered status and bus strobes, decoded from the upcoming state so
    // they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            chipselect_r <= 1'b0;
            write_r      <= 1'b0;
        end else begin
            busy_r       <= (state_s == S_RD) || (state_s == S_LAT) || (state_s == S_WR);
            done_r       <= (state_r == S_DONE);
            chipselect_r <= (state_s == S_RD) || (state_s == S_WR);
            write_r      <= (state_s == S_WR);
        end
    end

    // Address and write data. The address only moves for RD/WR and otherwise
    // holds; on the first RD the pointer is not latched yet, so the folded
    // input is used directly. writedata doubles as the LAT capture register.
    always_ff @(posedge clk) begin
        if (reset) begin
            address_r   <= {ADDR_W{1'b0}};
            writedata_r <= 32'd0;
        end else begin
            if (state_s == S_RD) begin
                address_r <= (state_r == S_IDLE) ? src_in_s : src_ptr_r;
            end else if (state_s == S_WR) begin
                address_r <= dst_ptr_r;
            end
            if (state_r == S_LAT) begin
                writedata_r <= bus.readdata;
            end
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign words_done     = words_done_r;
    assign bus.address    = address_r;
    assign bus.byteenable = 4'hF;
    assign bus.chipselect = chipselect_r;
    assign bus.write      = write_r;
    assign bus.writedata  = writedata_r;
    assign bus.clken      = ~reset;

endmodule

// File: tb/tb_onchip_mem_copy_master.sv
// ----------------------------------------------------------------------------
// tb_onchip_mem_copy_master
// Directed bench: RAM model on the bus, expected reads/writes queued when a
// job is issued and popped as the master drives the bus.
// ----------------------------------------------------------------------------
module tb_onchip_mem_copy_master;

    localparam int DEPTH = 20480;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [14:0] src_addr;
    logic [14:0] dst_addr;
    logic [14:0] length;
    logic        busy;
    logic        done;
    logic [14:0] words_done;
    logic        ram_init;

    int n_cmp  = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int cs_cnt = 0;

    int exp_rd[$];
    int exp_wr_a[$];
    logic [31:0] exp_wr_d[$];

    logic [31:0] mem    [0:DEPTH-1];
    logic [31:0] golden [0:DEPTH-1];
    logic [31:0] rd_q;

    onchip_mem_copy_master_if #(.ADDR_W(15)) bus ();

    onchip_mem_copy_master #(
        .ADDR_W(15), .MEM_DEPTH(DEPTH), .LEN_W(15)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done), .words_done(words_done), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pattern(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // RAM model: one-cycle read latency, no waitrequest.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= pattern(i);
        end else if (bus.clken && bus.chipselect) begin
            if (bus.write) mem[bus.address] <= bus.writedata;
            else           rd_q <= mem[bus.address];
        end
    end
    assign bus.readdata = rd_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        if (bus.chipselect) cs_cnt++;
        if (bus.chipselect && bus.write) begin
            wr_cnt++;
            chk("wr_expected", 32'(exp_wr_a.size() > 0), 32'd1);
            if (exp_wr_a.size() > 0) begin
                chk("wr_addr", 32'(bus.address), 32'(exp_wr_a.pop_front()));
                chk("wr_data", bus.writedata, exp_wr_d.pop_front());
            end
        end else if (bus.chipselect) begin
            chk("rd_expected", 32'(exp_rd.size() > 0), 32'd1);
            if (exp_rd.size() > 0) chk("rd_addr", 32'(bus.address), 32'(exp_rd.pop_front()));
        end
    end

    // Queue the reads/writes of a job, copying ascending in the golden image.
    task automatic expect_job(input int s, input int d, input int n);
        int sa, da;
        for (int i = 0; i < n; i++) begin
            sa = ((s % DEPTH) + i) % DEPTH;
            da = ((d % DEPTH) + i) % DEPTH;
            exp_rd.push_back(sa);
            exp_wr_a.push_back(da);
            exp_wr_d.push_back(golden[sa]);
            golden[da] = golden[sa];
        end
    endtask

    // Issue a job; lat = cycle of done counting the start cycle as 0.
    task automatic run_job(input int s, input int d, input int n,
                           input int abort_at, input int restart_at, output int lat);
        @(negedge clk);
        src_addr = 15'(s); dst_addr = 15'(d); length = 15'(n);
        start = 1'b1; abort = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start = (lat == restart_at);
            abort = (lat == abort_at);
            if (lat == restart_at) begin
                src_addr = 15'd900; dst_addr = 15'd950; length = 15'd5;
            end
        end while (!done && lat < 200);
        start = 1'b0; abort = 1'b0;
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic chk_queues(input string tag);
        chk({tag, "_rdq"}, 32'(exp_rd.size()), 32'd0);
        chk({tag, "_wrq"}, 32'(exp_wr_a.size()), 32'd0);
    endtask

    initial begin
        int lat, w0, c0, bad;
        for (int i = 0; i < DEPTH; i++) golden[i] = pattern(i);
        reset = 1'b1; ram_init = 1'b1; start = 1'b0; abort = 1'b0;
        src_addr = 15'd0; dst_addr = 15'd0; length = 15'd0;
        repeat (3) @(negedge clk);
        ram_init = 1'b0;

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cs", 32'(bus.chipselect), 32'd0);
        chk("rst_write", 32'(bus.write), 32'd0);
        chk("rst_words", 32'(words_done), 32'd0);
        chk("rst_addr", 32'(bus.address), 32'd0);
        chk("rst_wdata", bus.writedata, 32'd0);
        chk("rst_clken", 32'(bus.clken), 32'd0);
        chk("rst_be", 32'(bus.byteenable), 32'hF);
        reset = 1'b0;
        @(negedge clk);
        chk("clken_run", 32'(bus.clken), 32'd1);

        // Basic copy 100..103 -> 200..203
        w0 = wr_cnt;
        expect_job(100, 200, 4);
        run_job(100, 200, 4, -1, -1, lat);
        chk("basic_lat", 32'(lat), 32'd14);
        chk("basic_words", 32'(words_done), 32'd4);
        chk("basic_wrcnt", 32'(wr_cnt - w0), 32'd4);
        chk_queues("basic");
        repeat (4) @(negedge clk);
        chk("words_hold", 32'(words_done), 32'd4);
        for (int i = 0; i < 4; i++) chk("basic_mem", mem[200 + i], pattern(100 + i));

        // Zero length
        c0 = cs_cnt;
        run_job(300, 400, 0, -1, -1, lat);
        chk("zero_lat", 32'(lat), 32'd2);
        chk("zero_cs", 32'(cs_cnt - c0), 32'd0);
        chk("zero_words", 32'(words_done), 32'd0);

        // Wrap across the top of the RAM
        expect_job(20478, 10, 4);
        run_job(20478, 10, 4, -1, -1, lat);
        chk("wrap_lat", 32'(lat), 32'd14);
        chk_queues("wrap");

        // Start address above the RAM is folded once
        expect_job(DEPTH + 50, 60, 2);
        run_job(DEPTH + 50, 60, 2, -1, -1, lat);
        chk("fold_lat", 32'(lat), 32'd8);
        chk_queues("fold");

        // Forward overlap replicates data
        expect_job(1000, 1002, 4);
        run_job(1000, 1002, 4, -1, -1, lat);
        chk("ovl_lat", 32'(lat), 32'd14);
        chk("ovl_mem", mem[1005], pattern(1001));
        chk_queues("ovl");

        // Abort during the third word's LAT (cycle 8)
        w0 = wr_cnt;
        expect_job(300, 400, 3);
        run_job(300, 400, 10, 8, -1, lat);
        chk("abort_lat", 32'(lat), 32'd11);
        chk("abort_words", 32'(words_done), 32'd3);
        chk("abort_wrcnt", 32'(wr_cnt - w0), 32'd3);
        chk_queues("abort");

        // Ignored start while busy
        w0 = wr_cnt;
        expect_job(700, 800, 3);
        run_job(700, 800, 3, -1, 3, lat);
        chk("ign_lat", 32'(lat), 32'd11);
        repeat (30) @(negedge clk);
        chk("ign_busy", 32'(busy), 32'd0);
        chk("ign_wrcnt", 32'(wr_cnt - w0), 32'd3);
        chk("ign_words", 32'(words_done), 32'd3);
        chk_queues("ign");

        // Reset during the second word's RD (cycle 4)
        exp_rd.push_back(500); exp_rd.push_back(501);
        exp_wr_a.push_back(600); exp_wr_d.push_back(golden[500]);
        golden[600] = golden[500];
        @(negedge clk);
        src_addr = 15'd500; dst_addr = 15'd600; length = 15'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rd_cs", 32'(bus.chipselect), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_cs", 32'(bus.chipselect), 32'd0);
        chk("mid_write", 32'(bus.write), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_dst1", mem[601], pattern(601));
        chk_queues("mid");

        // Whole RAM against the golden image
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== golden[i]) bad++;
        chk("mem_final", 32'(bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
